// File: rtl/axis_pcp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_pcp_pkg
// Description : Shared constants and types for the PCP stream arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_pcp_pkg;

    localparam int PCP_VEC_LEN = 12;
    localparam int PCP_BEATS   = 2 * PCP_VEC_LEN;
    localparam int ERR_CNT_W   = 16;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

endpackage : axis_pcp_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; returns the first set
//               request at or after ptr, wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W:0] w_cand;

    // Scan from farthest to nearest so the request closest to ptr wins last.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_cand = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (w_cand >= (IDX_W + 1)'(N)) begin
                w_cand = w_cand - (IDX_W + 1)'(N);
            end
            if (req[w_cand[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/axis_pcp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_pcp_arbiter
// Description : Packet-granular round-robin AXI4-Stream arbiter; grant held
//               from first beat through TLAST. Optional framing checker
//               enabled by macro AXIS_PCP_ARB_FRAME_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_pcp_arbiter
    import axis_pcp_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 512,
    parameter int VEC_LEN = PCP_VEC_LEN
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    input  logic [NUM_SRC*DATA_W-1:0]     s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [DATA_W-1:0]             m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic [$clog2(NUM_SRC)-1:0]    grant_id,
    output logic                          busy,
    output logic                          frame_err,
    output logic [ERR_CNT_W-1:0]          err_cnt
);

    localparam int IDX_W = $clog2(NUM_SRC);

    if (NUM_SRC < 2 || NUM_SRC > 8 || VEC_LEN < 1) begin : g_param_check
        $error("axis_pcp_arbiter: unsupported NUM_SRC/VEC_LEN");
    end

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               busy_q, busy_d;

    logic               w_pick_vld;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_fire;
    logic               w_pkt_end;
    logic [DATA_W-1:0]  w_src_data [NUM_SRC];

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign w_src_data[i] = s_axis_tdata[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N     (NUM_SRC),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (s_axis_tvalid),
        .ptr   (ptr_q),
        .valid (w_pick_vld),
        .idx   (w_pick_idx)
    );

    // Pure combinational mux while locked; everything is quiet in IDLE.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (state_q == ARB_LOCK) begin
            m_axis_tvalid          = s_axis_tvalid[grant_q];
            m_axis_tdata           = w_src_data[grant_q];
            m_axis_tlast           = s_axis_tlast[grant_q];
            s_axis_tready[grant_q] = m_axis_tready;
        end
    end

    assign w_fire    = m_axis_tvalid & m_axis_tready;
    assign w_pkt_end = w_fire & m_axis_tlast;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        case (state_q)
            ARB_IDLE: begin
                if (w_pick_vld) begin
                    state_d = ARB_LOCK;
                    grant_d = w_pick_idx;
                    busy_d  = 1'b1;
                end
            end
            ARB_LOCK: begin
                if (w_pkt_end) begin
                    state_d = ARB_IDLE;
                    busy_d  = 1'b0;
                    ptr_d   = (grant_q == IDX_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = busy_q;

`ifdef AXIS_PCP_ARB_FRAME_CHECK_EN
    localparam int                CNT_W   = $clog2(2 * VEC_LEN + 1);
    localparam logic [CNT_W-1:0]  C_BEATS = CNT_W'(2 * VEC_LEN);

    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 w_frame_err;

    // Counter parks at C_BEATS once an overrun is flagged, so the late TLAST
    // of that same packet is not reported a second time.
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        w_frame_err = 1'b0;
        if (w_fire) begin
            if (m_axis_tlast) begin
                beat_cnt_d  = '0;
                w_frame_err = (beat_cnt_q != C_BEATS) && (beat_cnt_q + 1'b1 != C_BEATS);
            end else if (beat_cnt_q != C_BEATS) begin
                beat_cnt_d  = beat_cnt_q + 1'b1;
                w_frame_err = (beat_cnt_q + 1'b1 == C_BEATS);
            end
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (w_frame_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign frame_err = w_frame_err;
    assign err_cnt   = err_cnt_q;
`else
    assign frame_err = 1'b0;
    assign err_cnt   = '0;
`endif

endmodule : axis_pcp_arbiter
`default_nettype wire
